// File: rtl/led_frame_sequencer_if.sv
// Pixel-path bundle between the pixel FIFO, the frame sequencer and the serializer array.
//   fifo_data  : first-word-fall-through byte, valid while fifo_empty is low
//   fifo_empty : pixel FIFO empty
//   fifo_rd    : pop strobe, one byte per high cycle
//   ser_pixel  : pixel to load, {byte2, byte1, byte0}; byte2 shifts out first
//   ser_load   : one-hot, one-cycle load strobe per string
//   ser_ready  : serializer s can accept a pixel
//   ser_idle   : serializer s has finished shifting and its line is low
// master = sequencer side, slave = FIFO/serializer side.
interface led_frame_sequencer_if #(
    parameter int unsigned N_STRINGS = 5
);
    logic [7:0]           fifo_data;
    logic                 fifo_empty;
    logic                 fifo_rd;
    logic [23:0]          ser_pixel;
    logic [N_STRINGS-1:0] ser_load;
    logic [N_STRINGS-1:0] ser_ready;
    logic [N_STRINGS-1:0] ser_idle;

    modport master (
        input  fifo_data, fifo_empty, ser_ready, ser_idle,
        output fifo_rd, ser_pixel, ser_load
    );

    modport slave (
        output fifo_data, fifo_empty, ser_ready, ser_idle,
        input  fifo_rd, ser_pixel, ser_load
    );
endinterface

// File: rtl/led_frame_sequencer.sv
// Steers 3-byte pixels from the pixel FIFO to the per-string WS2812B serializers in
// pixel-major order, then enforces the latch gap after each frame or software hblank.
// Ports:
//   clk, rst    : system clock, synchronous active-high reset
//   bus         : FIFO read side and serializer load side (master modport)
//   hblank_req  : single-cycle software hblank request
//   busy        : high whenever the sequencer is not idle
//   frame_done  : one-cycle pulse at the end of each latch gap
//   frame_count : completed latches, wrapping
//   underrun    : sticky, FIFO ran dry while a string had already gone idle mid-frame
module led_frame_sequencer #(
    parameter int unsigned N_STRINGS         = 5,
    parameter int unsigned N_LEDS_PER_STRING = 8,
    parameter int unsigned LATCH_CYCLES      = 6000
) (
    input  logic                         clk,
    input  logic                         rst,
    led_frame_sequencer_if.master        bus,
    input  logic                         hblank_req,
    output logic                         busy,
    output logic                         frame_done,
    output logic [15:0]                  frame_count,
    output logic                         underrun
);
    localparam int unsigned STR_W = (N_STRINGS > 1) ? $clog2(N_STRINGS) : 1;
    localparam int unsigned PIX_W = (N_LEDS_PER_STRING > 1) ? $clog2(N_LEDS_PER_STRING) : 1;
    localparam int unsigned LAT_W = $clog2(LATCH_CYCLES);

    localparam logic [STR_W-1:0] STR_LAST = STR_W'(N_STRINGS - 1);
    localparam logic [PIX_W-1:0] PIX_LAST = PIX_W'(N_LEDS_PER_STRING - 1);
    localparam logic [LAT_W-1:0] LAT_LAST = LAT_W'(LATCH_CYCLES - 1);

    typedef enum logic [2:0] {
        StIdle, StGather, StWaitRdy, StLoad, StDrain, StLatch
    } state_e;

    state_e             state_q, state_d;
    logic [1:0]         byte_idx_q, byte_idx_d;
    logic [STR_W-1:0]   str_idx_q, str_idx_d;
    logic [PIX_W-1:0]   pix_idx_q, pix_idx_d;
    logic [LAT_W-1:0]   latch_cnt_q, latch_cnt_d;
    logic [23:0]        pixel_q, pixel_d;
    logic [15:0]        frame_count_q, frame_count_d;
    logic               underrun_q, underrun_d;

    logic                 fifo_rd;
    logic [N_STRINGS-1:0] load_vec;
    logic                 frame_in_prog;

    assign frame_in_prog = (pix_idx_q != '0) || (str_idx_q != '0) || (byte_idx_q != '0);

    always_comb begin
        state_d       = state_q;
        byte_idx_d    = byte_idx_q;
        str_idx_d     = str_idx_q;
        pix_idx_d     = pix_idx_q;
        latch_cnt_d   = latch_cnt_q;
        pixel_d       = pixel_q;
        frame_count_d = frame_count_q;
        underrun_d    = underrun_q;
        fifo_rd       = 1'b0;
        load_vec      = '0;
        frame_done    = 1'b0;

        unique case (state_q)
            StIdle: begin
                if (hblank_req) begin
                    state_d = StDrain;
                end else if (!bus.fifo_empty) begin
                    state_d = StGather;
                end
            end
            StGather: begin
                // Starved mid-frame while the current string has already run out of bits.
                if (frame_in_prog && bus.fifo_empty && bus.ser_idle[str_idx_q]) begin
                    underrun_d = 1'b1;
                end
                if (hblank_req) begin
                    // Partial pixel is abandoned; its popped bytes are gone.
                    byte_idx_d = '0;
                    state_d    = StDrain;
                end else if (!bus.fifo_empty) begin
                    fifo_rd = 1'b1;
                    case (byte_idx_q)
                        2'd0:    pixel_d[7:0]   = bus.fifo_data;
                        2'd1:    pixel_d[15:8]  = bus.fifo_data;
                        default: pixel_d[23:16] = bus.fifo_data;
                    endcase
                    if (byte_idx_q == 2'd2) begin
                        byte_idx_d = '0;
                        state_d    = StWaitRdy;
                    end else begin
                        byte_idx_d = byte_idx_q + 2'd1;
                    end
                end
            end
            StWaitRdy: begin
                if (hblank_req) begin
                    state_d = StDrain;
                end else if (bus.ser_ready[str_idx_q]) begin
                    state_d = StLoad;
                end
            end
            StLoad: begin
                load_vec[str_idx_q] = 1'b1;
                if (str_idx_q == STR_LAST) begin
                    str_idx_d = '0;
                    pix_idx_d = (pix_idx_q == PIX_LAST) ? '0 : pix_idx_q + PIX_W'(1);
                end else begin
                    str_idx_d = str_idx_q + STR_W'(1);
                end
                // An hblank arriving during the load lets this load finish first.
                if (((str_idx_q == STR_LAST) && (pix_idx_q == PIX_LAST)) || hblank_req) begin
                    state_d = StDrain;
                end else begin
                    state_d = StGather;
                end
            end
            StDrain: begin
                if (&bus.ser_idle) begin
                    latch_cnt_d = '0;
                    state_d     = StLatch;
                end
            end
            StLatch: begin
                if (latch_cnt_q == LAT_LAST) begin
                    frame_done    = 1'b1;
                    frame_count_d = frame_count_q + 16'd1;
                    byte_idx_d    = '0;
                    str_idx_d     = '0;
                    pix_idx_d     = '0;
                    latch_cnt_d   = '0;
                    state_d       = StIdle;
                end else begin
                    latch_cnt_d = latch_cnt_q + LAT_W'(1);
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= StIdle;
            byte_idx_q    <= '0;
            str_idx_q     <= '0;
            pix_idx_q     <= '0;
            latch_cnt_q   <= '0;
            pixel_q       <= '0;
            frame_count_q <= '0;
            underrun_q    <= 1'b0;
        end else begin
            state_q       <= state_d;
            byte_idx_q    <= byte_idx_d;
            str_idx_q     <= str_idx_d;
            pix_idx_q     <= pix_idx_d;
            latch_cnt_q   <= latch_cnt_d;
            pixel_q       <= pixel_d;
            frame_count_q <= frame_count_d;
            underrun_q    <= underrun_d;
        end
    end

    assign bus.fifo_rd   = fifo_rd;
    assign bus.ser_load  = load_vec;
    assign bus.ser_pixel = pixel_q;
    assign busy          = (state_q != StIdle);
    assign frame_count   = frame_count_q;
    assign underrun      = underrun_q;
endmodule

// File: tb/tb_led_frame_sequencer.sv
module tb_led_frame_sequencer;
    localparam int unsigned N  = 5;
    localparam int unsigned NL = 8;
    localparam int unsigned L  = 6000;
    localparam int FRAME_PIX   = N * NL;

    logic        clk = 1'b0;
    logic        rst;
    logic        hblank_req;
    logic        busy;
    logic        frame_done;
    logic [15:0] frame_count;
    logic        underrun;

    led_frame_sequencer_if #(.N_STRINGS(N)) bus ();

    led_frame_sequencer #(
        .N_STRINGS        (N),
        .N_LEDS_PER_STRING(NL),
        .LATCH_CYCLES     (L)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .bus        (bus),
        .hblank_req (hblank_req),
        .busy       (busy),
        .frame_done (frame_done),
        .frame_count(frame_count),
        .underrun   (underrun)
    );

    always #5 clk = ~clk;

    typedef struct {
        int          str;
        logic [23:0] pix;
        bit          last;
    } load_t;

    load_t      exp_q[$];
    logic [7:0] fifo_q[$];
    logic [7:0] fbytes [3*FRAME_PIX];

    int n_vec = 0;
    int n_err = 0;
    int cyc = 0;
    int drain_from = -1;
    int done_at = -1;
    bit gap = 1'b0;
    bit pop_pending = 1'b0;
    int pop_cnt = 0;
    int load_cnt = 0;
    int done_cnt = 0;
    int model_frames = 0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: observed 0x%0h, expected 0x%0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    task automatic refresh();
        bus.fifo_empty = (fifo_q.size() == 0);
        bus.fifo_data  = (fifo_q.size() != 0) ? fifo_q[0] : 8'h00;
    endtask

    task automatic push(input logic [7:0] b);
        fifo_q.push_back(b);
        refresh();
    endtask

    // Mid-cycle observation: expected loads, FIFO rules and latch-gap timing.
    task automatic monitor();
        load_t e;
        pop_pending = bus.fifo_rd;
        if (rst) begin
            drain_from   = -1;
            done_at      = -1;
            gap          = 1'b0;
            model_frames = 0;
            return;
        end
        if (hblank_req && !gap) begin
            drain_from = cyc + 1;
            gap        = 1'b1;
        end
        if (bus.fifo_rd) begin
            pop_cnt++;
            check_eq("rd_while_empty", 32'(bus.fifo_empty), 0);
            check_eq("rd_in_latch_gap", 32'(gap), 0);
        end
        if (bus.ser_load != '0) begin
            load_cnt++;
            if (exp_q.size() == 0) begin
                check_eq("unexpected_load", 32'(bus.ser_load), 0);
            end else begin
                e = exp_q.pop_front();
                check_eq("load_string", 32'(bus.ser_load), 32'(1) << e.str);
                check_eq("load_pixel", 32'(bus.ser_pixel), 32'(e.pix));
                if (e.last) begin
                    drain_from = cyc + 1;
                    gap        = 1'b1;
                end
            end
        end
        if (drain_from >= 0 && done_at < 0 && cyc >= drain_from && (&bus.ser_idle)) begin
            done_at = cyc + L;
        end
        if (done_at >= 0 && cyc == done_at) begin
            check_eq("frame_done_at_gap_end", 32'(frame_done), 1);
            model_frames++;
            drain_from = -1;
            done_at    = -1;
            gap        = 1'b0;
        end else if (frame_done) begin
            check_eq("frame_done_stray", cyc, done_at);
        end
        if (frame_done) done_cnt++;
    endtask

    task automatic step();
        @(negedge clk);
        monitor();
        @(posedge clk);
        cyc++;
        #1;
        if (pop_pending && fifo_q.size() != 0) void'(fifo_q.pop_front());
        refresh();
    endtask

    task automatic steps(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    task automatic new_frame();
        for (int i = 0; i < 3 * FRAME_PIX; i++) fbytes[i] = 8'($urandom);
    endtask

    // Load i of a frame goes to string i mod N with bytes 3i..3i+2.
    task automatic expect_pixels(input int npix, input bit ends);
        load_t e;
        for (int i = 0; i < npix; i++) begin
            e.str  = i % N;
            e.pix  = {fbytes[3*i+2], fbytes[3*i+1], fbytes[3*i]};
            e.last = ends && (i == npix - 1);
            exp_q.push_back(e);
        end
    endtask

    task automatic push_range(input int from, input int to);
        for (int i = from; i < to; i++) push(fbytes[i]);
    endtask

    task automatic wait_done(input int target, input int budget);
        int n = 0;
        while (done_cnt < target && n < budget) begin
            step();
            n++;
        end
        check_eq("wait_frame_done", done_cnt, target);
    endtask

    task automatic wait_loads(input int target, input int budget);
        int n = 0;
        while (load_cnt < target && n < budget) begin
            step();
            n++;
        end
        check_eq("wait_loads", load_cnt, target);
    endtask

    task automatic wait_pops(input int target, input int budget);
        int n = 0;
        while (pop_cnt < target && n < budget) begin
            step();
            n++;
        end
        check_eq("wait_pops", pop_cnt, target);
    endtask

    task automatic check_reset_outputs();
        check_eq("rst_fifo_rd", 32'(bus.fifo_rd), 0);
        check_eq("rst_ser_load", 32'(bus.ser_load), 0);
        check_eq("rst_ser_pixel", 32'(bus.ser_pixel), 0);
        check_eq("rst_busy", 32'(busy), 0);
        check_eq("rst_frame_done", 32'(frame_done), 0);
        check_eq("rst_frame_count", 32'(frame_count), 0);
        check_eq("rst_underrun", 32'(underrun), 0);
    endtask

    initial begin
        int base;
        rst            = 1'b1;
        hblank_req     = 1'b0;
        bus.ser_ready  = '1;
        bus.ser_idle   = '1;
        refresh();
        steps(3);
        rst = 1'b0;
        step();
        check_reset_outputs();

        // Single frame with every serializer ready and idle.
        new_frame();
        expect_pixels(FRAME_PIX, 1'b1);
        push_range(0, 3 * FRAME_PIX);
        wait_done(1, 8000);
        step();
        check_eq("single_frame_count", 32'(frame_count), model_frames);
        check_eq("single_loads_left", exp_q.size(), 0);
        check_eq("single_busy_after", 32'(busy), 0);

        // Two frames queued at once; the second waits out the latch gap.
        new_frame();
        expect_pixels(FRAME_PIX, 1'b1);
        push_range(0, 3 * FRAME_PIX);
        new_frame();
        expect_pixels(FRAME_PIX, 1'b1);
        push_range(0, 3 * FRAME_PIX);
        wait_done(3, 16000);
        step();
        check_eq("b2b_frame_count", 32'(frame_count), model_frames);
        check_eq("b2b_loads_left", exp_q.size(), 0);

        // Backpressure on string 2 of the first pixel row.
        base          = load_cnt;
        bus.ser_ready = ~(N'(1) << 2);
        new_frame();
        expect_pixels(FRAME_PIX, 1'b1);
        push_range(0, 3 * FRAME_PIX);
        base = pop_cnt;
        steps(500);
        check_eq("stall_loads", load_cnt % FRAME_PIX, 2);
        check_eq("stall_pops", pop_cnt - base, 9);
        check_eq("stall_no_load_now", 32'(bus.ser_load), 0);
        check_eq("stall_busy", 32'(busy), 1);
        bus.ser_ready = '1;
        steps(3);
        check_eq("release_one_load", load_cnt % FRAME_PIX, 3);
        wait_done(4, 8000);
        step();
        check_eq("bp_frame_count", 32'(frame_count), model_frames);

        // hblank while the second pixel is only partly gathered.
        bus.ser_idle = '0;
        new_frame();
        expect_pixels(1, 1'b0);
        base = pop_cnt;
        push_range(0, 4);
        wait_pops(base + 4, 50);
        hblank_req = 1'b1;
        step();
        hblank_req = 1'b0;
        steps(3);
        check_eq("hblank_no_underrun", 32'(underrun), 0);
        check_eq("hblank_loads_left", exp_q.size(), 0);
        check_eq("hblank_busy", 32'(busy), 1);
        bus.ser_idle = '1;
        wait_done(5, 7000);
        step();
        check_eq("hblank_frame_count", 32'(frame_count), model_frames);

        // Underrun: FIFO dries up halfway while string 0 finishes shifting.
        bus.ser_idle = '0;
        new_frame();
        expect_pixels(FRAME_PIX, 1'b1);
        base = load_cnt;
        push_range(0, 3 * FRAME_PIX / 2);
        wait_loads(base + FRAME_PIX / 2, 500);
        steps(10);
        check_eq("underrun_not_yet", 32'(underrun), 0);
        bus.ser_idle[0] = 1'b1;
        steps(2);
        check_eq("underrun_set", 32'(underrun), 1);
        bus.ser_idle = '1;
        steps(5);
        check_eq("underrun_sticky", 32'(underrun), 1);
        push_range(3 * FRAME_PIX / 2, 3 * FRAME_PIX);
        wait_done(6, 8000);
        step();
        check_eq("underrun_frame_count", 32'(frame_count), model_frames);
        check_eq("underrun_still_set", 32'(underrun), 1);
        check_eq("underrun_loads_left", exp_q.size(), 0);

        // Reset roughly halfway through the latch gap.
        new_frame();
        expect_pixels(FRAME_PIX, 1'b1);
        push_range(0, 3 * FRAME_PIX);
        base = 0;
        while ((done_at < 0 || cyc < done_at - int'(L) / 2) && base < 8000) begin
            step();
            base++;
        end
        check_eq("reached_mid_latch", 32'(done_at >= 0), 1);
        base = done_cnt;
        rst  = 1'b1;
        step();
        rst = 1'b0;
        check_reset_outputs();
        steps(L + 100);
        check_eq("no_done_after_rst", done_cnt, base);
        check_eq("count_after_rst", 32'(frame_count), model_frames);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
